// File: rtl/jtag_vdr_bank.sv
// jtag_vdr_bank: JTAG data-register bank with address, data, flags and write-strobe registers
module jtag_vdr_bank #(
    parameter int          DR_LENGTH   = 32,
    parameter int          IR_LENGTH   = 4,
    parameter int          ADDR_WIDTH  = 16,
    parameter logic [31:0] IDENT_VALUE = 32'h4A544147
) (
    input  logic                  tck,
    input  logic                  reset,
    input  logic                  tdi,
    input  logic [IR_LENGTH-1:0]  ir,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    output logic                  tdo,
    input  logic [DR_LENGTH-1:0]  rdata_in,
    output logic [DR_LENGTH-1:0]  wdata_out,
    output logic [ADDR_WIDTH-1:0] raddr_out,
    output logic [ADDR_WIDTH-1:0] waddr_out,
    output logic [DR_LENGTH-1:0]  flags_out,
    output logic                  wram_enable,
    output logic [DR_LENGTH-1:0]  wcount_out
);
    typedef enum logic [2:0] {
        OP_IDENT, OP_RADDR, OP_WADDR, OP_RDATA, OP_WDATA, OP_FLAGS, OP_WCOUNT, OP_BYPASS
    } op_t;
    op_t                   op;
    logic [DR_LENGTH-1:0]  sr, cap, wdata, flags, wcount;
    logic [ADDR_WIDTH-1:0] raddr, waddr;
    logic                  byp;
    always_comb begin
        op  = (ir < IR_LENGTH'(7)) ? op_t'(ir[2:0]) : OP_BYPASS;
        cap = op == OP_IDENT  ? DR_LENGTH'(IDENT_VALUE) :
              op == OP_RADDR  ? DR_LENGTH'(raddr) :
              op == OP_WADDR  ? DR_LENGTH'(waddr) :
              op == OP_RDATA  ? rdata_in :
              op == OP_WDATA  ? wdata :
              op == OP_FLAGS  ? flags :
              op == OP_WCOUNT ? wcount : '0;
    end
    // Strobe-cycle increments come first so a coincident update overrides them.
    always_ff @(posedge tck) begin
        if (reset) begin
            sr          <= '0;
            byp         <= 1'b0;
            raddr       <= '0;
            waddr       <= '0;
            wdata       <= '0;
            flags       <= '0;
            wcount      <= '0;
            wram_enable <= 1'b0;
        end else begin
            wram_enable <= 1'b0;
            if (wram_enable) begin
                wcount <= wcount + DR_LENGTH'(1);
                if (flags[0]) waddr <= waddr + ADDR_WIDTH'(1);
            end
            if (capture_dr) begin
                sr  <= cap;
                byp <= 1'b0;
            end else if (shift_dr) begin
                sr  <= {tdi, sr[DR_LENGTH-1:1]};
                byp <= tdi;
            end else if (update_dr) begin
                case (op)
                    OP_RADDR:  raddr <= sr[ADDR_WIDTH-1:0];
                    OP_WADDR:  waddr <= sr[ADDR_WIDTH-1:0];
                    OP_RDATA:  if (flags[1]) raddr <= raddr + ADDR_WIDTH'(1);
                    OP_WDATA:  begin
                        wdata       <= sr;
                        wram_enable <= 1'b1;
                    end
                    OP_FLAGS:  flags <= sr;
                    OP_WCOUNT: wcount <= '0;
                    default:   ;
                endcase
            end
        end
    end
    assign tdo        = op == OP_BYPASS ? byp : sr[0];
    assign wdata_out  = wdata;
    assign raddr_out  = raddr;
    assign waddr_out  = waddr;
    assign flags_out  = flags;
    assign wcount_out = wcount;
endmodule

// File: tb/tb_jtag_vdr_bank.sv
// tb_jtag_vdr_bank: directed vector bench for jtag_vdr_bank (DR_LENGTH=32, ADDR_WIDTH=16)
module tb_jtag_vdr_bank;
    logic        tck = 1'b0;
    logic        reset, tdi, capture_dr, shift_dr, update_dr, tdo, wram_enable;
    logic [3:0]  ir;
    logic [31:0] rdata_in, wdata_out, flags_out, wcount_out;
    logic [15:0] raddr_out, waddr_out;
    int          n_cmp = 0;
    int          n_fail = 0;

    jtag_vdr_bank dut (
        .tck(tck), .reset(reset), .tdi(tdi), .ir(ir),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .tdo(tdo), .rdata_in(rdata_in), .wdata_out(wdata_out),
        .raddr_out(raddr_out), .waddr_out(waddr_out), .flags_out(flags_out),
        .wram_enable(wram_enable), .wcount_out(wcount_out)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic [3:0]  ir;
        logic [31:0] din;
        logic [31:0] rdata;
        logic [31:0] word;
        logic        wen;
        logic [15:0] raddr;
        logic [15:0] waddr;
        logic [31:0] wdata;
        logic [31:0] flags;
        logic [31:0] wcount;
    } vec_t;
    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input logic c, input logic s, input logic u, input logic d);
        capture_dr = c;
        shift_dr   = s;
        update_dr  = u;
        tdi        = d;
        @(posedge tck);
        #1;
    endtask

    task automatic shift_word(input logic [31:0] din, output logic [31:0] dout);
        for (int i = 0; i < 32; i++) begin
            dout[i] = tdo;
            tick(1'b0, 1'b1, 1'b0, din[i]);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] din, output logic [31:0] dout);
        ir = op;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        shift_word(din, dout);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wdata"}, wdata_out, 32'h0);
        chk({tag, "_raddr"}, {16'h0, raddr_out}, 32'h0);
        chk({tag, "_waddr"}, {16'h0, waddr_out}, 32'h0);
        chk({tag, "_flags"}, flags_out, 32'h0);
        chk({tag, "_wcount"}, wcount_out, 32'h0);
        chk({tag, "_wen"}, {31'h0, wram_enable}, 32'h0);
    endtask

    initial begin
        logic [31:0] w;
        vt[0]  = '{4'h0, 32'h12345678, 32'h0,        32'h4A544147, 1'b0, 16'h0000, 16'h0000, 32'h0,        32'h0,        32'h0};
        vt[1]  = '{4'h1, 32'hDEAD1234, 32'h0,        32'h00000000, 1'b0, 16'h1234, 16'h0000, 32'h0,        32'h0,        32'h0};
        vt[2]  = '{4'h1, 32'h0000BEEF, 32'h0,        32'h00001234, 1'b0, 16'hBEEF, 16'h0000, 32'h0,        32'h0,        32'h0};
        vt[3]  = '{4'h2, 32'hFFFF00AA, 32'h0,        32'h00000000, 1'b0, 16'hBEEF, 16'h00AA, 32'h0,        32'h0,        32'h0};
        vt[4]  = '{4'h5, 32'hF0000000, 32'h0,        32'h00000000, 1'b0, 16'hBEEF, 16'h00AA, 32'h0,        32'hF0000000, 32'h0};
        vt[5]  = '{4'h3, 32'h11111111, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 16'hBEEF, 16'h00AA, 32'h0,        32'hF0000000, 32'h0};
        vt[6]  = '{4'h4, 32'h87654321, 32'h0,        32'h00000000, 1'b1, 16'hBEEF, 16'h00AA, 32'h87654321, 32'hF0000000, 32'h1};
        vt[7]  = '{4'h6, 32'h00000005, 32'h0,        32'h00000001, 1'b0, 16'hBEEF, 16'h00AA, 32'h87654321, 32'hF0000000, 32'h0};
        vt[8]  = '{4'hF, 32'hA5A5A5A5, 32'h0,        32'h4B4B4B4A, 1'b0, 16'hBEEF, 16'h00AA, 32'h87654321, 32'hF0000000, 32'h0};
        vt[9]  = '{4'h7, 32'h00000001, 32'h0,        32'h00000002, 1'b0, 16'hBEEF, 16'h00AA, 32'h87654321, 32'hF0000000, 32'h0};
        vt[10] = '{4'h5, 32'h00000003, 32'h0,        32'hF0000000, 1'b0, 16'hBEEF, 16'h00AA, 32'h87654321, 32'h00000003, 32'h0};
        vt[11] = '{4'h3, 32'h00000000, 32'h0BADBEEF, 32'h0BADBEEF, 1'b0, 16'hBEF0, 16'h00AA, 32'h87654321, 32'h00000003, 32'h0};
        vt[12] = '{4'h4, 32'h00000055, 32'h0,        32'h87654321, 1'b1, 16'hBEF0, 16'h00AB, 32'h00000055, 32'h00000003, 32'h1};
        vt[13] = '{4'h6, 32'hFFFFFFFF, 32'h0,        32'h00000001, 1'b0, 16'hBEF0, 16'h00AB, 32'h00000055, 32'h00000003, 32'h0};
        reset = 1'b1; ir = 4'h0; rdata_in = '0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk_zero("reset");
        chk("reset_tdo", {31'h0, tdo}, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            rdata_in = vt[k].rdata;
            run(vt[k].ir, vt[k].din, w);
            chk($sformatf("v%0d_word", k), w, vt[k].word);
            chk($sformatf("v%0d_wen", k), {31'h0, wram_enable}, {31'h0, vt[k].wen});
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d_raddr", k), {16'h0, raddr_out}, {16'h0, vt[k].raddr});
            chk($sformatf("v%0d_waddr", k), {16'h0, waddr_out}, {16'h0, vt[k].waddr});
            chk($sformatf("v%0d_wdata", k), wdata_out, vt[k].wdata);
            chk($sformatf("v%0d_flags", k), flags_out, vt[k].flags);
            chk($sformatf("v%0d_wcount", k), wcount_out, vt[k].wcount);
        end
        // reset coincident with a WDATA update: the update and its strobe never happen
        ir = 4'h4;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        shift_word(32'h99, w);
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        chk_zero("rst_upd");
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_upd_nopulse", {31'h0, wram_enable}, 32'h0);
        // reset during the strobe cycle suppresses the pending increments
        run(4'h5, 32'h1, w);
        run(4'h2, 32'h0010, w);
        run(4'h4, 32'h77, w);
        chk("rst_strobe_wen", {31'h0, wram_enable}, 32'h1);
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk_zero("rst_strobe");
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_strobe_after", {31'h0, wram_enable}, 32'h0);
        // auto-incrementing write burst
        run(4'h5, 32'h1, w);
        run(4'h2, 32'h00FF, w);
        for (int k = 0; k < 3; k++) begin
            run(4'h4, 32'hA + k, w);
            chk($sformatf("burst%0d_wen", k), {31'h0, wram_enable}, 32'h1);
            chk($sformatf("burst%0d_waddr", k), {16'h0, waddr_out}, 32'h00FF + k);
            chk($sformatf("burst%0d_wdata", k), wdata_out, 32'hA + k);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("burst%0d_wen_off", k), {31'h0, wram_enable}, 32'h0);
        end
        chk("burst_wcount", wcount_out, 32'h3);
        chk("burst_waddr_end", {16'h0, waddr_out}, 32'h0102);
        // WCOUNT clear during a strobe cycle wins over the increment
        run(4'h4, 32'h1234, w);
        ir = 4'h6;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_strobe_wcount", wcount_out, 32'h0);
        chk("clr_strobe_waddr", {16'h0, waddr_out}, 32'h0103);
        chk("clr_strobe_wen", {31'h0, wram_enable}, 32'h0);
        // WADDR update during a strobe cycle wins over the auto-increment
        run(4'h4, 32'h2222, w);
        ir = 4'h2;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("waddr_strobe_waddr", {16'h0, waddr_out}, 32'h2222);
        chk("waddr_strobe_wcount", wcount_out, 32'h1);
        // auto-incrementing reads with wrap and capture-edge sampling
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        run(4'h5, 32'h2, w);
        run(4'h1, 32'hFFFF, w);
        chk("rd_raddr0", {16'h0, raddr_out}, 32'hFFFF);
        ir = 4'h3;
        rdata_in = 32'h11112222;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        rdata_in = 32'hDEADDEAD;
        shift_word(32'h0, w);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rd_word1", w, 32'h11112222);
        chk("rd_raddr1", {16'h0, raddr_out}, 32'h0000);
        rdata_in = 32'h33334444;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        rdata_in = 32'hDEADDEAD;
        shift_word(32'h0, w);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rd_word2", w, 32'h33334444);
        chk("rd_raddr2", {16'h0, raddr_out}, 32'h0001);
        // capture > shift > update
        ir = 4'h1;
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("prio_cap_tdo", {31'h0, tdo}, 32'h1);
        chk("prio_cap_raddr", {16'h0, raddr_out}, 32'h0001);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("prio_shift_tdo", {31'h0, tdo}, 32'h0);
        chk("prio_shift_raddr", {16'h0, raddr_out}, 32'h0001);
        // one-cycle bypass delay
        ir = 4'hF;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("byp_tdo0", {31'h0, tdo}, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("byp_tdo1", {31'h0, tdo}, 32'h1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("byp_tdo2", {31'h0, tdo}, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("byp_tdo3", {31'h0, tdo}, 32'h1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
